demux1to4_reg: RTL and testbench

Registered 1-to-4 demultiplexer with per-channel valid/ready handshake. It is the distribution counterpart of the 4:1 selector in the mux library: one input word is steered by `{s1,s0}` into one of four single-entry output registers, and each register holds the word until its consumer takes it. It sits between a single producer and four independent consumers, and provides backpressure per channel.

---
 rtl/demux1to4_reg.sv | 119 +++++++++++
 tb/tb_demux1to4_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready holding registers.
// Optional auto-scan select pointer enabled by defining DEMUX_SCAN_EN.

module demux1to4_reg_ch #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             r_i,
  output logic [WIDTH-1:0] y_o,
  output logic             v_o
);
  logic [WIDTH-1:0] y_q, y_d;
  logic             v_q, v_d;

  // A load wins over a consume so a word taken this cycle is replaced without a bubble.
  always_comb begin
    y_d = y_q;
    v_d = v_q;
    if (ld_i) begin
      y_d = d_i;
      v_d = 1'b1;
    end else if (v_q && r_i) begin
      y_d = '0;
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign y_o = y_q;
  assign v_o = v_q;
endmodule

module demux1to4_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3
`ifdef DEMUX_SCAN_EN
  ,
  input  logic             scan
`endif
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            r_vec, v_vec, ld_vec;
  logic [NUM_LANES-1:0][WIDTH-1:0] y_vec;
  logic [1:0]                      sel;
  logic                            accept;

  assign r_vec = {r3, r2, r1, r0};

`ifdef DEMUX_SCAN_EN
  logic [1:0] ptr_q, ptr_d;

  // Pointer advances only on an accepted word while scanning; wraps naturally at 2 bits.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && scan) ptr_d = ptr_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end

  assign sel = scan ? ptr_q : {s1, s0};
`else
  assign sel = {s1, s0};
`endif

  assign in_ready = !rst && (!v_vec[sel] || r_vec[sel]);
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign ld_vec[i] = accept && (sel == i[1:0]);

    demux1to4_reg_ch #(.WIDTH(WIDTH)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .ld_i (ld_vec[i]),
      .d_i  (d),
      .r_i  (r_vec[i]),
      .y_o  (y_vec[i]),
      .v_o  (v_vec[i])
    );
  end

  assign {y3, y2, y1, y0} = y_vec;
  assign {v3, v2, v1, v0} = v_vec;
endmodule

// File: tb/tb_demux1to4_reg.sv
// Directed, table-driven bench for demux1to4_reg (WIDTH=4); scan sequence runs only with DEMUX_SCAN_EN.

module tb_demux1to4_reg;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d;
  logic         s0, s1, in_valid, in_ready;
  logic [W-1:0] y0, y1, y2, y3;
  logic         v0, v1, v2, v3;
  logic         r0, r1, r2, r3;
`ifdef DEMUX_SCAN_EN
  logic         scan;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux1to4_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .d(d), .s0(s0), .s1(s1),
    .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3)
`ifdef DEMUX_SCAN_EN
    , .scan(scan)
`endif
  );

  typedef struct {
    logic        iv;
    logic [1:0]  s;
    logic [3:0]  d;
    logic [3:0]  r;    // {r3,r2,r1,r0}
    logic        rdy;  // in_ready before the edge
    logic [3:0]  v;    // {v3..v0} after the edge
    logic [15:0] y;    // {y3,y2,y1,y0} after the edge
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic iv, input logic [1:0] s, input logic [3:0] dd,
                      input logic [3:0] r, input logic rdy, input logic [3:0] v, input logic [15:0] y);
    @(negedge clk);
    in_valid = iv;
    {s1, s0} = s;
    d = dd;
    {r3, r2, r1, r0} = r;
    #1 chk({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    #1;
    chk({name, ".v"}, {28'd0, v3, v2, v1, v0}, {28'd0, v});
    chk({name, ".y"}, {16'd0, y3, y2, y1, y0}, {16'd0, y});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    //          iv  s     d     r        rdy v        y
    // steering, all consumers ready
    tbl[0]  = '{1, 2'd0, 4'h1, 4'hF,    1, 4'b0001, 16'h0001};
    tbl[1]  = '{1, 2'd1, 4'h1, 4'hF,    1, 4'b0010, 16'h0010};
    tbl[2]  = '{1, 2'd2, 4'h1, 4'hF,    1, 4'b0100, 16'h0100};
    tbl[3]  = '{1, 2'd3, 4'h1, 4'hF,    1, 4'b1000, 16'h1000};
    tbl[4]  = '{0, 2'd3, 4'h0, 4'hF,    1, 4'b0000, 16'h0000};
    // backpressure on channel 2
    tbl[5]  = '{1, 2'd2, 4'h1, 4'h0,    1, 4'b0100, 16'h0100};
    tbl[6]  = '{1, 2'd2, 4'h0, 4'h0,    0, 4'b0100, 16'h0100};
    tbl[7]  = '{1, 2'd2, 4'h0, 4'h0,    0, 4'b0100, 16'h0100};
    tbl[8]  = '{1, 2'd2, 4'h0, 4'b0100, 1, 4'b0100, 16'h0000};
    tbl[9]  = '{0, 2'd2, 4'h0, 4'b0100, 1, 4'b0000, 16'h0000};
    // consume and reload channel 1 in the same cycle
    tbl[10] = '{1, 2'd1, 4'h5, 4'h0,    1, 4'b0010, 16'h0050};
    tbl[11] = '{1, 2'd1, 4'h0, 4'b0010, 1, 4'b0010, 16'h0000};
    tbl[12] = '{0, 2'd1, 4'h0, 4'b0010, 1, 4'b0000, 16'h0000};
    // independent channels 0 and 3
    tbl[13] = '{1, 2'd0, 4'h3, 4'h0,    1, 4'b0001, 16'h0003};
    tbl[14] = '{1, 2'd3, 4'h9, 4'h0,    1, 4'b1001, 16'h9003};
    tbl[15] = '{0, 2'd1, 4'h0, 4'h0,    1, 4'b1001, 16'h9003};
    tbl[16] = '{0, 2'd0, 4'h0, 4'h0,    0, 4'b1001, 16'h9003};
    tbl[17] = '{0, 2'd0, 4'h0, 4'b1001, 1, 4'b0000, 16'h0000};
    // ready on empty channels has no effect
    tbl[18] = '{0, 2'd0, 4'h0, 4'hF,    1, 4'b0000, 16'h0000};

    rst = 1'b1; d = '0; s0 = 0; s1 = 0; in_valid = 0;
    r0 = 0; r1 = 0; r2 = 0; r3 = 0;
`ifdef DEMUX_SCAN_EN
    scan = 1'b0;
`endif
    #2;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset.v", {28'd0, v3, v2, v1, v0}, 32'd0);
    chk("reset.y", {16'd0, y3, y2, y1, y0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("release.in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 19; i++)
      step($sformatf("vec%0d", i), tbl[i].iv, tbl[i].s, tbl[i].d, tbl[i].r,
           tbl[i].rdy, tbl[i].v, tbl[i].y);

    // reset mid-operation with channels 0 and 2 holding data
    step("fill0", 1, 2'd0, 4'h6, 4'h0, 1, 4'b0001, 16'h0006);
    step("fill2", 1, 2'd2, 4'hA, 4'h0, 1, 4'b0101, 16'h0A06);
    @(negedge clk);
    in_valid = 0; {s1, s0} = 2'd0;
    #1 rst = 1'b1;
    #1;
    chk("midrst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst.v", {28'd0, v3, v2, v1, v0}, 32'd0);
    chk("midrst.y", {16'd0, y3, y2, y1, y0}, 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_rel.in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_rel.v", {28'd0, v3, v2, v1, v0}, 32'd0);
    step("after_rst", 1, 2'd1, 4'h7, 4'h0, 1, 4'b0010, 16'h0070);
    step("drain", 0, 2'd1, 4'h0, 4'hF, 1, 4'b0000, 16'h0000);

`ifdef DEMUX_SCAN_EN
    @(negedge clk);
    scan = 1'b1;
    step("scan0", 1, 2'd3, 4'h1, 4'hF, 1, 4'b0001, 16'h0001);
    step("scan1", 1, 2'd3, 4'h2, 4'hF, 1, 4'b0010, 16'h0020);
    step("scan2", 1, 2'd3, 4'h3, 4'hF, 1, 4'b0100, 16'h0300);
    step("scan3", 1, 2'd3, 4'h4, 4'hF, 1, 4'b1000, 16'h4000);
    step("scan4", 1, 2'd3, 4'h5, 4'hF, 1, 4'b0001, 16'h0005);
    @(negedge clk);
    scan = 1'b0;
    step("noscan", 1, 2'd3, 4'h6, 4'hF, 1, 4'b1000, 16'h6000);
    @(negedge clk);
    scan = 1'b1;
    step("scan_hold", 1, 2'd3, 4'h7, 4'hF, 1, 4'b0010, 16'h0070);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
